// File: rtl/isa_seq_pkg.sv
// Shared types and default timing for the ISA I/O cycle sequencer.
package isa_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    HOLD
  } seq_state_e;

  localparam int unsigned DEF_SETUP_CYCLES   = 2;
  localparam int unsigned DEF_STROBE_CYCLES  = 8;
  localparam int unsigned DEF_HOLD_CYCLES    = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;
  localparam int unsigned DEF_CNT_W          = 9;

  // Value a floating ISA data bus reads back as; reported on a timed-out read.
  localparam logic [15:0] ISA_FLOAT_DATA = 16'hFFFF;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the values from before the edge and the chain really delays by two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/isa_cycle_sequencer.sv
// Sequences one ISA I/O read or write cycle (setup, strobe, IOCHRDY wait, hold)
// per start pulse and reports read data, done and timeout to the register file.
module isa_cycle_sequencer
  import isa_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        cmd_write,
  input  logic        cmd_wide,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] rdata,
  output logic [15:0] isa_sa,
  output logic        isa_sbhe_n,
  output logic        isa_ior_n,
  output logic        isa_iow_n,
  output logic [15:0] isa_d_out,
  output logic        isa_d_oe,
  input  logic [15:0] isa_d_in,
  input  logic        isa_iochrdy
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [15:0]      sa_q, sa_d;
  logic             sbhe_n_q, sbhe_n_d;
  logic             ior_n_q, ior_n_d;
  logic             iow_n_q, iow_n_d;
  logic [15:0]      d_out_q, d_out_d;
  logic             d_oe_q, d_oe_d;
  logic             rdy_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rdy_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (isa_iochrdy),
    .q_o   (rdy_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
      sa_q      <= '0;
      sbhe_n_q  <= 1'b1;
      ior_n_q   <= 1'b1;
      iow_n_q   <= 1'b1;
      d_out_q   <= '0;
      d_oe_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
      sa_q      <= sa_d;
      sbhe_n_q  <= sbhe_n_d;
      ior_n_q   <= ior_n_d;
      iow_n_q   <= iow_n_d;
      d_out_q   <= d_out_d;
      d_oe_q    <= d_oe_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets its hold default first, so no branch
    // below can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;
    sa_d      = sa_q;
    sbhe_n_d  = sbhe_n_q;
    ior_n_d   = ior_n_q;
    iow_n_d   = iow_n_q;
    d_out_d   = d_out_q;
    d_oe_d    = d_oe_q;

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      ior_n_d  = 1'b1;
      iow_n_d  = 1'b1;
      d_oe_d   = 1'b0;
      sbhe_n_d = 1'b1;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // abort in the same cycle suppresses the command.
          if (start && !abort) begin
            sa_d      = cmd_addr;
            d_out_d   = cmd_wdata;
            sbhe_n_d  = ~cmd_wide;
            d_oe_d    = cmd_write;
            write_d   = cmd_write;
            busy_d    = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = SETUP_LOAD;
            state_d   = SETUP;
          end
        end

        SETUP: begin
          if (cnt_q == CNT_ZERO) begin
            iow_n_d = ~write_q;
            ior_n_d = write_q;
            cnt_d   = STROBE_LOAD;
            state_d = STROBE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        STROBE: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (rdy_s) begin
            if (!write_q) rdata_d = isa_d_in;
            ior_n_d = 1'b1;
            iow_n_d = 1'b1;
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
          end else begin
            cnt_d   = CNT_ZERO;
            state_d = WAIT;
          end
        end

        WAIT: begin
          if (rdy_s) begin
            if (!write_q) rdata_d = isa_d_in;
            ior_n_d = 1'b1;
            iow_n_d = 1'b1;
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
          end else if (cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            if (!write_q) rdata_d = ISA_FLOAT_DATA;
            ior_n_d = 1'b1;
            iow_n_d = 1'b1;
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        HOLD: begin
          if (cnt_q == CNT_ZERO) begin
            d_oe_d   = 1'b0;
            sbhe_n_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign rdata      = rdata_q;
  assign isa_sa     = sa_q;
  assign isa_sbhe_n = sbhe_n_q;
  assign isa_ior_n  = ior_n_q;
  assign isa_iow_n  = iow_n_q;
  assign isa_d_out  = d_out_q;
  assign isa_d_oe   = d_oe_q;

endmodule

// File: tb/tb_isa_cycle_sequencer.sv
// Directed self-checking bench for isa_cycle_sequencer with default timing.
module tb_isa_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, cmd_write, cmd_wide;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        busy, done, timeout;
  logic [15:0] rdata, isa_sa, isa_d_out, isa_d_in;
  logic        isa_sbhe_n, isa_ior_n, isa_iow_n, isa_d_oe, isa_iochrdy;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] IDLE_CTRL = 6'b001101;

  isa_cycle_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cmd_write   (cmd_write),
    .cmd_wide    (cmd_wide),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .rdata       (rdata),
    .isa_sa      (isa_sa),
    .isa_sbhe_n  (isa_sbhe_n),
    .isa_ior_n   (isa_ior_n),
    .isa_iow_n   (isa_iow_n),
    .isa_d_out   (isa_d_out),
    .isa_d_oe    (isa_d_oe),
    .isa_d_in    (isa_d_in),
    .isa_iochrdy (isa_iochrdy)
  );

  always #5 clk = ~clk;

  // Expected {busy, done, ior_n, iow_n, d_oe, sbhe_n} in cycle k after the
  // start edge, for a cycle whose strobe is last low in cycle e.
  function automatic logic [5:0] exp_ctrl(int k, bit wr, bit wide, int e);
    logic b, d, low;
    b   = (k >= 1) && (k <= e + 2);
    d   = (k == e + 3);
    low = (k >= 3) && (k <= e);
    return {b, d, !(low && !wr), !(low && wr), wr && b, !(wide && b)};
  endfunction

  function automatic logic [5:0] ctrl_now();
    return {busy, done, isa_ior_n, isa_iow_n, isa_d_oe, isa_sbhe_n};
  endfunction

  // Drives a one-clock start; returns at the falling edge inside cycle T1.
  task automatic issue(input bit wr, input bit wide, input logic [15:0] addr,
                       input logic [15:0] wdata);
    @(negedge clk);
    cmd_write = wr;
    cmd_wide  = wide;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    #23;
    got = {busy, done, timeout, isa_ior_n, isa_iow_n, isa_d_oe, isa_sbhe_n};
    checks++;
    if (got !== 7'b0001101) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected %b", got, 7'b0001101);
    end
    checks++;
    if ({rdata, isa_sa, isa_d_out} !== 48'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {rdata, isa_sa, isa_d_out});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    issue(1'b1, 1'b0, 16'h0220, 16'h00A5);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (ctrl_now() !== exp_ctrl(k, 1'b1, 1'b0, 10)) begin
        failures++;
        $display("FAIL write_ctrl T%0d: got %b expected %b", k, ctrl_now(),
                 exp_ctrl(k, 1'b1, 1'b0, 10));
      end
      checks++;
      if ({isa_sa, isa_d_out} !== {16'h0220, 16'h00A5}) begin
        failures++;
        $display("FAIL write_bus T%0d: got %h/%h expected 0220/00a5", k, isa_sa, isa_d_out);
      end
    end
  endtask

  task automatic test_read();
    isa_d_in = 16'h1234;
    issue(1'b0, 1'b1, 16'h022A, 16'h0000);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (ctrl_now() !== exp_ctrl(k, 1'b0, 1'b1, 10) || isa_sa !== 16'h022A) begin
        failures++;
        $display("FAIL read_ctrl T%0d: got %b/%h expected %b/022a", k, ctrl_now(), isa_sa,
                 exp_ctrl(k, 1'b0, 1'b1, 10));
      end
      if (k == 13) begin
        checks++;
        if (rdata !== 16'hBEEF || timeout !== 1'b0) begin
          failures++;
          $display("FAIL read_data: got %h/%b expected beef/0", rdata, timeout);
        end
      end
      // Valid data only in the last strobe-low cycle pins the sampling edge.
      if (k == 10) isa_d_in = 16'hBEEF;
      if (k == 11) isa_d_in = 16'h5555;
    end
  endtask

  task automatic test_wait_states();
    isa_d_in = 16'h1357;
    issue(1'b0, 1'b0, 16'h0300, 16'h0000);
    for (int k = 1; k <= 31; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (ctrl_now() !== exp_ctrl(k, 1'b0, 1'b0, 26)) begin
        failures++;
        $display("FAIL wait_ctrl T%0d: got %b expected %b", k, ctrl_now(),
                 exp_ctrl(k, 1'b0, 1'b0, 26));
      end
      if (k == 29) begin
        checks++;
        if (rdata !== 16'h1357 || timeout !== 1'b0) begin
          failures++;
          $display("FAIL wait_data: got %h/%b expected 1357/0", rdata, timeout);
        end
      end
      if (k == 4)  isa_iochrdy = 1'b0;
      if (k == 24) isa_iochrdy = 1'b1;
    end
  endtask

  task automatic test_timeout();
    isa_d_in    = 16'h2468;
    isa_iochrdy = 1'b0;
    issue(1'b0, 1'b0, 16'h0310, 16'h0000);
    for (int k = 1; k <= 270; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (ctrl_now() !== exp_ctrl(k, 1'b0, 1'b0, 266)) begin
        failures++;
        $display("FAIL timeout_ctrl T%0d: got %b expected %b", k, ctrl_now(),
                 exp_ctrl(k, 1'b0, 1'b0, 266));
      end
      if (k == 269) begin
        checks++;
        if (rdata !== 16'hFFFF || timeout !== 1'b1) begin
          failures++;
          $display("FAIL timeout_flag: got %h/%b expected ffff/1", rdata, timeout);
        end
      end
    end
    isa_iochrdy = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout);
    end
    issue(1'b1, 1'b0, 16'h0320, 16'h0042);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (ctrl_now() !== exp_ctrl(k, 1'b1, 1'b0, 10) || timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_clear T%0d: got %b/%b expected %b/0", k, ctrl_now(), timeout,
                 exp_ctrl(k, 1'b1, 1'b0, 10));
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] exp;
    issue(1'b1, 1'b0, 16'h0330, 16'h1111);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      exp = (k <= 6) ? exp_ctrl(k, 1'b1, 1'b0, 10) : IDLE_CTRL;
      checks++;
      if (ctrl_now() !== exp || isa_sa !== 16'h0330) begin
        failures++;
        $display("FAIL abort_ctrl T%0d: got %b/%h expected %b/0330", k, ctrl_now(), isa_sa, exp);
      end
      if (k == 4) begin
        cmd_addr = 16'h0555;
        start    = 1'b1;
      end
      if (k == 5) start = 1'b0;
      if (k == 6) abort = 1'b1;
      if (k == 7) abort = 1'b0;
    end
    checks++;
    if (rdata !== 16'hFFFF || timeout !== 1'b0) begin
      failures++;
      $display("FAIL abort_status: got %h/%b expected ffff/0", rdata, timeout);
    end
    @(negedge clk);
    cmd_addr = 16'h0777;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || isa_sa !== 16'h0330) begin
      failures++;
      $display("FAIL abort_priority: got %b/%h expected 0/0330", busy, isa_sa);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] got;
    issue(1'b0, 1'b1, 16'h0444, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (ctrl_now() !== exp_ctrl(k, 1'b0, 1'b1, 10)) begin
        failures++;
        $display("FAIL pre_reset_ctrl T%0d: got %b expected %b", k, ctrl_now(),
                 exp_ctrl(k, 1'b0, 1'b1, 10));
      end
    end
    reset = 1'b0;
    #1;
    got = {busy, done, timeout, isa_ior_n, isa_iow_n, isa_d_oe, isa_sbhe_n};
    checks++;
    if (got !== 7'b0001101 || {rdata, isa_sa, isa_d_out} !== 48'h0) begin
      failures++;
      $display("FAIL async_reset: got %b/%h expected 0001101/0", got,
               {rdata, isa_sa, isa_d_out});
    end
    @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 1'b0, 16'h0220, 16'h5A5A);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (ctrl_now() !== exp_ctrl(k, 1'b1, 1'b0, 10) || isa_d_out !== 16'h5A5A) begin
        failures++;
        $display("FAIL post_reset T%0d: got %b/%h expected %b/5a5a", k, ctrl_now(), isa_d_out,
                 exp_ctrl(k, 1'b1, 1'b0, 10));
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    cmd_write   = 1'b0;
    cmd_wide    = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    isa_d_in    = '0;
    isa_iochrdy = 1'b1;
    #3 reset = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/isa_cycle_sequencer.md
Name: isa_cycle_sequencer

Overview:
- Runs one ISA I/O bus cycle per command, driven by the host-side address/data/control registers.
- Takes the latched 16-bit address, 16-bit write data and control bits, and sequences setup, strobe (IOR#/IOW#), IOCHRDY wait-state extension and hold.
- Returns read data and done/timeout status to the register file.
- Sits between the register file and the riser's ISA pin drivers.

Parameters:
- SETUP_CYCLES, 2, clocks address/data valid before strobe (min 1)
- STROBE_CYCLES, 8, minimum strobe-low clocks (min 1)
- HOLD_CYCLES, 2, clocks address/data held after strobe release (min 1)
- TIMEOUT_CYCLES, 256, maximum extra wait-state clocks before abort-with-timeout
- CNT_W, 9, width of the shared phase/timeout counter; must hold max(parameters)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-clock command pulse from the control register go bit
- abort  in  1  control_reset from the register file; kills the cycle in progress
- cmd_write  in  1  1 = I/O write, 0 = I/O read
- cmd_wide  in  1  1 = 16-bit transfer (SBHE# asserted)
- cmd_addr  in  16  I/O address
- cmd_wdata  in  16  write data
- busy  out  1  cycle in progress
- done  out  1  one-clock completion pulse
- timeout  out  1  sticky; last cycle hit TIMEOUT_CYCLES; cleared on accepted start
- rdata  out  16  captured read data, held until the next read completes
- isa_sa  out  16  ISA address
- isa_sbhe_n  out  1  byte-high enable
- isa_ior_n  out  1  I/O read strobe
- isa_iow_n  out  1  I/O write strobe
- isa_d_out  out  16  write data to bus
- isa_d_oe  out  1  data bus driver enable
- isa_d_in  in  16  bus read data
- isa_iochrdy  in  1  async ready from card (high = ready)

Behaviour:
- Reset values (async on reset low): busy=0, done=0, timeout=0, rdata=0, isa_sa=0, isa_sbhe_n=1, isa_ior_n=1, isa_iow_n=1, isa_d_out=0, isa_d_oe=0, state=IDLE.
- All outputs registered. isa_iochrdy passes through a 2-flop synchronizer; only rdy_s is used.
- States:
  - IDLE: on start, latch cmd_* into isa_sa/isa_d_out/isa_sbhe_n(=~cmd_wide), set isa_d_oe=cmd_write, busy=1, timeout=0, cnt=SETUP_CYCLES-1, go to SETUP. start while busy is ignored.
  - SETUP: cnt==0 -> assert isa_iow_n or isa_ior_n low, cnt=STROBE_CYCLES-1, go to STROBE; else cnt--.
  - STROBE: cnt!=0 -> cnt--. cnt==0 and rdy_s=1 -> capture (read: rdata<=isa_d_in), release strobe, cnt=HOLD_CYCLES-1, go to HOLD. cnt==0 and rdy_s=0 -> cnt=0, go to WAIT.
  - WAIT: strobe stays low. rdy_s=1 -> capture, release strobe, go to HOLD. cnt==TIMEOUT_CYCLES-1 -> timeout=1, read sets rdata=16'hFFFF, release strobe, go to HOLD; else cnt++.
  - HOLD: strobe high; address/data/d_oe still driven. cnt==0 -> d_oe=0, sbhe_n=1, busy=0, done=1 for one clock, go to IDLE (isa_sa keeps its value).
- Latency with no wait states: busy high for SETUP+STROBE+HOLD clocks (default 12); done in the next clock. Strobe low exactly STROBE_CYCLES clocks. Read data is sampled on the clock edge that releases the strobe.
- Wait states extend the strobe by the number of WAIT clocks (synchronizer delay included); never beyond STROBE_CYCLES+TIMEOUT_CYCLES.
- abort (any non-IDLE state): next edge strobes high, d_oe=0, sbhe_n=1, busy=0, go to IDLE. No done, rdata and timeout unchanged. abort has priority over start in the same cycle.
- start and done never coincide. A start arriving in the done cycle is accepted (state is already IDLE).

Decomposition:
- Package isa_seq_pkg: state enum (IDLE, SETUP, STROBE, WAIT, HOLD), default timing constants, 16'hFFFF float value.
- One sub-module: sync_2ff (generic 2-flop synchronizer, reset to 1) for isa_iochrdy.

Test Plan:
- Write, defaults, iochrdy=1: addr 0x0220, data 0x00A5, start at T0 -> isa_sa=0x0220 and d_oe=1 for T1–T12, iow_n low T3–T10, ior_n=1 throughout, sbhe_n=1, done at T13 only.
- Read, cmd_wide=1, addr 0x022A, isa_d_in=0xBEEF -> ior_n low 8 clocks, d_oe=0, sbhe_n=0 during T1–T12, rdata=0xBEEF at done, timeout=0.
- Wait states: iochrdy low T4–T23 -> strobe stays low until rdy_s returns high (about T25), done 3 clocks after release, timeout=0.
- Timeout: iochrdy stuck low on a read -> strobe low 8+256 clocks, timeout=1, rdata=0xFFFF, done pulses; the next start clears timeout.
- Abort at T6 of a write -> iow_n=1, d_oe=0, busy=0 at T7, no done; a start pulse at T4 (while busy) is ignored.
- reset low mid-STROBE -> all outputs take reset values with no clock edge; the first start after release runs a normal 12-clock cycle.
